// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the SRAM BIST controller.
// Element order, scan direction and data polarity live here so the controller stays table-driven.
package sram_bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  typedef enum logic [2:0] {
    M0,
    M1,
    M2,
    M3,
    M4,
    M5
  } elem_e;

  typedef enum logic {
    OP_R,
    OP_W
  } op_e;

  // Direction table: 1 = descending address order.
  function automatic logic elem_down(elem_e e);
    case (e)
      M3, M4:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Op-count table: M0 and M5 issue one op per address, the rest issue two.
  function automatic logic elem_two_ops(elem_e e);
    case (e)
      M0, M5:  return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic op_e elem_op(elem_e e, logic opi);
    if (!elem_two_ops(e)) begin
      return (e == M0) ? OP_W : OP_R;
    end
    return opi ? OP_W : OP_R;
  endfunction

  // Polarity table: 0 selects the background word, 1 its complement.
  function automatic logic elem_pol(elem_e e, logic opi);
    case (e)
      M1, M3:  return opi;
      M2, M4:  return ~opi;
      default: return 1'b0;
    endcase
  endfunction

  function automatic elem_e elem_next(elem_e e);
    case (e)
      M0:      return M1;
      M1:      return M2;
      M2:      return M3;
      M3:      return M4;
      M4:      return M5;
      default: return M5;
    endcase
  endfunction

endpackage

// File: rtl/sram_bist_cmp.sv
// Read-data compare stage: stages each read's address and expected word, compares the macro
// output one cycle later and keeps a sticky capture of the first mismatch.
module sram_bist_cmp #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              rd_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_exp_i,
  input  logic [DATA_W-1:0] dout_i,
  output logic              fail_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_exp_o,
  output logic [DATA_W-1:0] fail_act_o
);

  logic              pend_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [DATA_W-1:0] pend_exp_q;
  logic              fail_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_exp_q;
  logic [DATA_W-1:0] fail_act_q;
  logic              mismatch;

  assign mismatch = pend_q && (dout_i != pend_exp_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_exp_q  <= '0;
    end else begin
      pend_q      <= rd_i;
      pend_addr_q <= rd_addr_i;
      pend_exp_q  <= rd_exp_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
    end else if (clear_i) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
    end else if (mismatch && !fail_q) begin
      fail_q      <= 1'b1;
      fail_addr_q <= pend_addr_q;
      fail_exp_q  <= pend_exp_q;
      fail_act_q  <= dout_i;
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_exp_o  = fail_exp_q;
  assign fail_act_o  = fail_act_q;

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller driving the A_BIST_* port of an IHP SG13G2 single-port SRAM.
// One op per RUN cycle from registered outputs; read data is checked by sram_bist_cmp.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int unsigned       ADDR_W = 9,
  parameter int unsigned       DATA_W = 8,
  parameter logic [DATA_W-1:0] BG     = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_exp_o,
  output logic [DATA_W-1:0] fail_act_o,
  output logic              bist_en_o,
  output logic              bist_men_o,
  output logic              bist_wen_o,
  output logic              bist_ren_o,
  output logic [ADDR_W-1:0] bist_addr_o,
  output logic [DATA_W-1:0] bist_din_o,
  output logic [DATA_W-1:0] bist_bm_o,
  input  logic [DATA_W-1:0] sram_dout_i
);

  state_e            state_q;
  logic              run_q;
  logic              done_q;

  // Pointer to the op currently on the bist_* outputs.
  elem_e             elem_q;
  logic              opi_q;
  logic [ADDR_W-1:0] addr_q;

  logic              men_q;
  logic              wen_q;
  logic              ren_q;
  logic [ADDR_W-1:0] baddr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] bm_q;
  logic [DATA_W-1:0] exp_q;

  logic              start_ok;
  logic              at_end;
  logic              last_op;
  logic              load;
  elem_e             nxt_elem;
  logic              nxt_opi;
  logic [ADDR_W-1:0] nxt_addr;
  elem_e             ld_elem;
  logic              ld_opi;
  logic [ADDR_W-1:0] ld_addr;
  op_e               ld_op;
  logic [DATA_W-1:0] ld_word;

  assign start_ok = start_i && ((state_q == StIdle) || (state_q == StDone));
  assign at_end   = elem_down(elem_q) ? (addr_q == '0) : (addr_q == '1);

  // Advance order: second op at the same address, then next address, then next element.
  always_comb begin
    nxt_elem = elem_q;
    nxt_opi  = 1'b0;
    nxt_addr = addr_q;
    last_op  = 1'b0;
    if (elem_two_ops(elem_q) && !opi_q) begin
      nxt_opi = 1'b1;
    end else if (!at_end) begin
      nxt_addr = elem_down(elem_q) ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
    end else begin
      last_op  = (elem_q == M5);
      nxt_elem = elem_next(elem_q);
      nxt_addr = elem_down(nxt_elem) ? '1 : '0;
    end
  end

  always_comb begin
    load    = start_ok || ((state_q == StRun) && !last_op);
    ld_elem = start_ok ? M0 : nxt_elem;
    ld_opi  = start_ok ? 1'b0 : nxt_opi;
    ld_addr = start_ok ? '0 : nxt_addr;
    ld_op   = elem_op(ld_elem, ld_opi);
    ld_word = elem_pol(ld_elem, ld_opi) ? ~BG : BG;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q <= StRun;
            run_q   <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StRun: begin
          if (last_op) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          state_q <= StDone;
          run_q   <= 1'b0;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      elem_q  <= M0;
      opi_q   <= 1'b0;
      addr_q  <= '0;
      men_q   <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      baddr_q <= '0;
      din_q   <= '0;
      bm_q    <= '0;
      exp_q   <= '0;
    end else if (load) begin
      elem_q  <= ld_elem;
      opi_q   <= ld_opi;
      addr_q  <= ld_addr;
      men_q   <= 1'b1;
      wen_q   <= (ld_op == OP_W);
      ren_q   <= (ld_op == OP_R);
      baddr_q <= ld_addr;
      din_q   <= (ld_op == OP_W) ? ld_word : '0;
      bm_q    <= (ld_op == OP_W) ? '1 : '0;
      exp_q   <= ld_word;
    end else begin
      men_q   <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      baddr_q <= '0;
      din_q   <= '0;
      bm_q    <= '0;
      exp_q   <= '0;
    end
  end

  sram_bist_cmp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_cmp (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (start_ok),
    .rd_i       (ren_q),
    .rd_addr_i  (baddr_q),
    .rd_exp_i   (exp_q),
    .dout_i     (sram_dout_i),
    .fail_o     (fail_o),
    .fail_addr_o(fail_addr_o),
    .fail_exp_o (fail_exp_o),
    .fail_act_o (fail_act_o)
  );

  assign busy_o      = run_q;
  assign done_o      = done_q;
  assign bist_en_o   = run_q;
  assign bist_men_o  = men_q;
  assign bist_wen_o  = wen_q;
  assign bist_ren_o  = ren_q;
  assign bist_addr_o = baddr_q;
  assign bist_din_o  = din_q;
  assign bist_bm_o   = bm_q;

endmodule

// File: doc/sram_march_bist.md
# sram_march_bist

Single-clock March C- built-in self-test controller for the single-port IHP SG13G2 SRAM macros with byte mask and BIST port (e.g. the 512x8 instance). It sits directly upstream of the macro. It drives the macro's A_BIST_* port group and consumes its A_DOUT. It reports pass/fail plus first-failure diagnostics to the DFT/test controller.

## Interface
- ADDR_W, 9: address width; the array depth is 2**ADDR_W.
- DATA_W, 8: word width; equals the bit-mask width.
- BG, {DATA_W{1'b0}}: background word. "0" = BG, "1" = ~BG.

Ports:
- clk_i, input, 1: the single clock. It also drives the macro's A_BIST_CLK.
- rst_ni, input, 1: asynchronous, active-low reset.
- start_i, input, 1: start request; sampled only in IDLE or DONE.
- busy_o, output, 1: high in RUN and DRAIN.
- done_o, output, 1: level; high in DONE.
- fail_o, output, 1: sticky; a mismatch has been seen in this run.
- fail_addr_o, output, ADDR_W: address of the first mismatch.
- fail_exp_o, output, DATA_W: expected word at the first mismatch.
- fail_act_o, output, DATA_W: read word at the first mismatch.
- bist_en_o, output, 1: to A_BIST_EN; high in RUN and DRAIN.
- bist_men_o, output, 1: to A_BIST_MEN.
- bist_wen_o, output, 1: to A_BIST_WEN.
- bist_ren_o, output, 1: to A_BIST_REN.
- bist_addr_o, output, ADDR_W: to A_BIST_ADDR.
- bist_din_o, output, DATA_W: to A_BIST_DIN.
- bist_bm_o, output, DATA_W: to A_BIST_BM; all ones whenever bist_wen_o is high, otherwise 0.
- sram_dout_i, input, DATA_W: from A_DOUT.

## Operation
- States:
  - IDLE: waits for start_i.
  - RUN: issues the march operations.
  - DRAIN: one cycle for the last compare.
  - DONE: holds results.
- Transitions:
  - IDLE→RUN on start_i.
  - RUN→DRAIN after the last op of M5.
  - DRAIN→DONE.
  - DONE→RUN on start_i. This restart clears fail_o, fail_addr_o, fail_exp_o and fail_act_o.
- start_i is ignored in RUN and DRAIN.
- March elements, with N = 2**ADDR_W:
  - M0 ⇑(w0)
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇑(r0)
- ⇑ runs addresses 0→N-1 and ⇓ runs N-1→0.
- Within an element, the r and w operations at the same address occupy consecutive cycles, r first.
- The address counter wraps only at element boundaries. The next element reloads it to 0 or N-1.
- Each RUN cycle issues exactly one op:
  - bist_men_o=1.
  - Exactly one of bist_wen_o and bist_ren_o is high.
  - bist_din_o = BG or ~BG on writes and 0 on reads.
- Outside RUN, bist_men_o, bist_wen_o and bist_ren_o are 0.
- Compare stage: each read registers (addr, expected). On the following cycle, sram_dout_i is compared against expected.
- On a mismatch while fail_o=0: set fail_o and capture the address, expected word and actual word.
- Later mismatches do not overwrite the first capture. The test always runs to completion.

## Timing
- Reset value of every output is 0. While rst_ni is low: all outputs are 0 and the state is IDLE.
- Reset asserted mid-run aborts immediately, with no completion of the pending op or compare.
- Operation count is 2N + 8N = 10N ops, i.e. 5120 for ADDR_W=9.
- With start_i high at edge 0:
  - The first op is driven after edge 0 and sampled by the macro at edge 1.
  - The last op is sampled at edge 10N.
  - Its compare completes, and done_o rises, at edge 10N+1.
- Read latency: data for a read sampled at edge k is valid before edge k+1 and compared at edge k+1.
- A mismatch from a read sampled at edge k makes fail_o visible after edge k+1.

## Structure
- Shared package sram_bist_pkg holds:
  - the state enum;
  - the march element enum M0..M5;
  - the op enum (OP_R, OP_W);
  - per-element constant tables: direction, op count, and the data polarity of each op.
- The controller uses one sub-module, sram_bist_cmp. It holds the registered expected word and address, performs the compare, and owns the sticky first-fail capture.
- The top level holds the FSM, the element/op/address counters and the output registers.

## Test plan
- Fault-free behavioural macro, ADDR_W=9, BG=8'h00, start pulse at edge 0:
  - done_o rises at edge 5121 and fail_o=0.
  - busy_o is high at edges 1..5120.
- Sequence check:
  - Ops 0..511 are writes of 8'h00 to addresses 0..511.
  - Op 512 is a read of address 0; op 513 is a write of 8'hFF to address 0.
  - M3 starts with a read of address 511.
  - bist_bm_o=8'hFF on every write.
- Stuck-at-0 on bit 3 at address 0x1A5:
  - fail_o=1, fail_addr_o=0x1A5, fail_exp_o=8'hFF, fail_act_o=8'hF7.
  - The capture is not overwritten by the later M4 mismatch at the same address.
  - done_o still rises at edge 5121.
- BG=8'h55:
  - M0 writes 8'h55 and M1 writes 8'hAA.
  - A fault-free run passes.
- rst_ni low at edge 2000:
  - All outputs are 0 immediately.
  - A new start produces a full 5121-edge run with clean fail state.
- Start handling:
  - start_i held high during RUN has no effect.
  - start_i in DONE after a failing run clears fail_o within 1 cycle and re-runs the full test.
